// File: rtl/sap1_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// sap1_fetch_unit_if
//   Bundles the SAP-1 control word, program-load port and W-bus connections
//   of the fetch unit so the controller side and the datapath side share one
//   typed connection.
//
//   Signals
//     cntrl_bus  12      {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
//     prog_we    1       program-load write strobe
//     prog_addr  ADDR_W  program-load address
//     prog_data  DATA_W  program-load data
//     w_bus_in   DATA_W  W-bus value from external slices
//     w_bus_out  DATA_W  value the fetch unit drives onto the W-bus
//     w_bus_oe   1       fetch unit drives the W-bus this cycle
//     opcode     4       instruction register upper nibble
//     pc         ADDR_W  program counter
//     mar        ADDR_W  memory address register
//     bus_err    1       sticky W-bus contention flag
//
//   Modports
//     master  controller / surrounding system side
//     slave   fetch unit side
// ---------------------------------------------------------------------------
interface sap1_fetch_unit_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [11:0]       cntrl_bus;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] w_bus_in;
  logic [DATA_W-1:0] w_bus_out;
  logic              w_bus_oe;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic              bus_err;

  modport master (
    output cntrl_bus, prog_we, prog_addr, prog_data, w_bus_in,
    input  w_bus_out, w_bus_oe, opcode, pc, mar, bus_err
  );

  modport slave (
    input  cntrl_bus, prog_we, prog_addr, prog_data, w_bus_in,
    output w_bus_out, w_bus_oe, opcode, pc, mar, bus_err
  );
endinterface

// File: rtl/sap1_fetch_unit.sv
// ---------------------------------------------------------------------------
// sap1_fetch_unit
//   Datapath end of the SAP-1 12-bit control bus. Holds the program counter,
//   memory address register, 16x8 program RAM and instruction register,
//   obeys control word bits 11..6 and returns the opcode to the controller.
//
//   Ports
//     clk   system clock, all state updates on the rising edge
//     clr   asynchronous active-low reset (pc, mar, ir, bus_err; not RAM)
//     bus   sap1_fetch_unit_if.slave: control word, program-load port,
//           W-bus in/out/oe, opcode, pc, mar, bus_err
//
//   Configuration
//     BUS_CONFLICT_EN  when defined, bus_err is set at an edge where more
//                      than one internal driver is active and held until
//                      clr; when undefined, bus_err is tied to 0.
// ---------------------------------------------------------------------------
module sap1_fetch_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic              clk,
  input logic              clr,
  sap1_fetch_unit_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Control word decode; bits 5..0 belong to other slices.
  logic cp, ep, lm_n, ce_n, li_n, ei_n;
  assign {cp, ep, lm_n, ce_n, li_n, ei_n} = bus.cntrl_bus[11:6];

  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^bus.cntrl_bus[5:0];

  logic [ADDR_W-1:0] pc_q,  pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q,  ir_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] int_bus;
  logic              drive_en;

  // Internal W-bus: Ep > CE > Ei, else whatever the external slices drive.
  // RAM read is asynchronous from mar, so loads in the same word see the
  // pre-edge RAM and register contents.
  always_comb begin
    int_bus = bus.w_bus_in;
    if (ep)
      int_bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    else if (!ce_n)
      int_bus = mem[mar_q];
    else if (!ei_n)
      int_bus = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
  end

  assign drive_en      = ep | ~ce_n | ~ei_n;
  assign bus.w_bus_oe  = drive_en;
  assign bus.w_bus_out = drive_en ? int_bus : '0;

  always_comb begin
    pc_d  = cp    ? pc_q + 1'b1              : pc_q;
    mar_d = !lm_n ? int_bus[ADDR_W-1:0]      : mar_q;
    ir_d  = !li_n ? int_bus                  : ir_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q  <= '0;
      mar_q <= '0;
      ir_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      mar_q <= mar_d;
      ir_q  <= ir_d;
    end
  end

  // NOTE: the program RAM has no reset; clr must leave a loaded program intact
  // and a reset would also prevent mapping onto RAM primitives.
  always_ff @(posedge clk) begin
    if (bus.prog_we)
      mem[bus.prog_addr] <= bus.prog_data;
  end

`ifdef BUS_CONFLICT_EN
  logic bus_err_q, bus_err_d;
  logic conflict;

  assign conflict  = (ep & ~ce_n) | (ep & ~ei_n) | (~ce_n & ~ei_n);
  assign bus_err_d = bus_err_q | conflict;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) bus_err_q <= 1'b0;
    else      bus_err_q <= bus_err_d;
  end

  assign bus.bus_err = bus_err_q;
`else
  assign bus.bus_err = 1'b0;
`endif

  assign bus.opcode = ir_q[DATA_W-1 -: 4];
  assign bus.pc     = pc_q;
  assign bus.mar    = mar_q;

endmodule

// File: tb/tb_sap1_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_sap1_fetch_unit
//   Directed bench for sap1_fetch_unit: reset, fetch/load, bus driving,
//   read-before-write, pc wrap, external load, Cp+Ep and bus conflict.
// ---------------------------------------------------------------------------
module tb_sap1_fetch_unit;

  localparam logic [11:0] W_IDLE   = 12'h3E3;
  localparam logic [11:0] W_EP_LM  = 12'h5E3;
  localparam logic [11:0] W_CP     = 12'hBE3;
  localparam logic [11:0] W_CE_LI  = 12'h263;
  localparam logic [11:0] W_EI_LM  = 12'h1A3;
  localparam logic [11:0] W_CE     = 12'h2E3;
  localparam logic [11:0] W_LI     = 12'h363;
  localparam logic [11:0] W_EP     = 12'h7E3;
  localparam logic [11:0] W_CPEPLM = 12'hDE3;
  localparam logic [11:0] W_EP_CE  = 12'h6E3;

`ifdef BUS_CONFLICT_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sap1_fetch_unit_if #(.ADDR_W(4), .DATA_W(8)) bus_if ();

  sap1_fetch_unit #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if.slave)
  );

  // Apply a word for one rising edge; returns 1 time unit after the edge.
  task automatic step(input logic [11:0] w);
    bus_if.cntrl_bus = w;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr = 1'b0;
    bus_if.cntrl_bus = W_IDLE;
    bus_if.prog_we = 1'b0;
    bus_if.prog_addr = '0;
    bus_if.prog_data = '0;
    bus_if.w_bus_in = 8'hC3;
    #12;
    if (bus_if.pc !== 4'h0) begin
      $display("FAIL reset_pc got %h want 0", bus_if.pc); miscompares++;
    end
    vectors++;
    if (bus_if.w_bus_oe !== 1'b0) begin
      $display("FAIL reset_idle_oe got %b want 0", bus_if.w_bus_oe); miscompares++;
    end
    vectors++;
    #2 clr = 1'b1;
    @(posedge clk); #1;
    step(W_CP);
    step(W_CP);
    step(W_EP_LM);  // mar <= 2
    step(W_LI);     // ir <= C3
    if (bus_if.pc !== 4'h2 || bus_if.mar !== 4'h2 || bus_if.opcode !== 4'hC) begin
      $display("FAIL prerun_state got pc=%h mar=%h op=%h want pc=2 mar=2 op=C",
               bus_if.pc, bus_if.mar, bus_if.opcode);
      miscompares++;
    end
    vectors++;
    // Asynchronous clear mid-cycle with Ep active: drivers follow zero state.
    bus_if.cntrl_bus = W_EP;
    #2 clr = 1'b0;
    #1;
    if (bus_if.pc !== 4'h0 || bus_if.mar !== 4'h0 || bus_if.opcode !== 4'h0 ||
        bus_if.bus_err !== 1'b0) begin
      $display("FAIL async_clr got pc=%h mar=%h op=%h err=%b want all 0",
               bus_if.pc, bus_if.mar, bus_if.opcode, bus_if.bus_err);
      miscompares++;
    end
    vectors++;
    if (bus_if.w_bus_out !== 8'h00 || bus_if.w_bus_oe !== 1'b1) begin
      $display("FAIL clr_ep_drive got out=%h oe=%b want 00/1",
               bus_if.w_bus_out, bus_if.w_bus_oe);
      miscompares++;
    end
    vectors++;
    bus_if.cntrl_bus = W_IDLE;
    #1;
    if (bus_if.w_bus_oe !== 1'b0) begin
      $display("FAIL clr_idle_oe got %b want 0", bus_if.w_bus_oe); miscompares++;
    end
    vectors++;
    clr = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch;
    bus_if.prog_we = 1'b1;
    bus_if.prog_addr = 4'h0; bus_if.prog_data = 8'h19; step(W_IDLE);
    bus_if.prog_addr = 4'h9; bus_if.prog_data = 8'h5A; step(W_IDLE);
    bus_if.prog_we = 1'b0;
    step(W_EP_LM);
    if (bus_if.mar !== 4'h0) begin
      $display("FAIL fetch_mar got %h want 0", bus_if.mar); miscompares++;
    end
    vectors++;
    step(W_CP);
    if (bus_if.pc !== 4'h1) begin
      $display("FAIL fetch_pc got %h want 1", bus_if.pc); miscompares++;
    end
    vectors++;
    step(W_CE_LI);
    if (bus_if.opcode !== 4'h1) begin
      $display("FAIL fetch_opcode got %h want 1", bus_if.opcode); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_drive;
    bus_if.cntrl_bus = W_EI_LM;
    #1;
    if (bus_if.w_bus_out !== 8'h09 || bus_if.w_bus_oe !== 1'b1) begin
      $display("FAIL ei_drive got out=%h oe=%b want 09/1",
               bus_if.w_bus_out, bus_if.w_bus_oe);
      miscompares++;
    end
    vectors++;
    step(W_EI_LM);
    if (bus_if.mar !== 4'h9) begin
      $display("FAIL ei_lm_mar got %h want 9", bus_if.mar); miscompares++;
    end
    vectors++;
    bus_if.cntrl_bus = W_CE;
    #1;
    if (bus_if.w_bus_out !== 8'h5A || bus_if.w_bus_oe !== 1'b1) begin
      $display("FAIL ce_drive got out=%h oe=%b want 5A/1",
               bus_if.w_bus_out, bus_if.w_bus_oe);
      miscompares++;
    end
    vectors++;
    // Same-edge write and CE read of address 9: ir gets the old 5A.
    bus_if.prog_we = 1'b1; bus_if.prog_addr = 4'h9; bus_if.prog_data = 8'h77;
    step(W_CE_LI);
    bus_if.prog_we = 1'b0;
    if (bus_if.opcode !== 4'h5) begin
      $display("FAIL rbw_opcode got %h want 5", bus_if.opcode); miscompares++;
    end
    vectors++;
    bus_if.cntrl_bus = W_CE;
    #1;
    if (bus_if.w_bus_out !== 8'h77) begin
      $display("FAIL rbw_newdata got %h want 77", bus_if.w_bus_out); miscompares++;
    end
    vectors++;
    @(posedge clk); #1;
  endtask

  task automatic test_pc_wrap;
    #2 clr = 1'b0;
    #2 clr = 1'b1;
    bus_if.cntrl_bus = W_CE;
    #1;
    if (bus_if.w_bus_out !== 8'h19) begin
      $display("FAIL ram_kept got %h want 19", bus_if.w_bus_out); miscompares++;
    end
    vectors++;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      step(W_CP);
      if (i == 14 && bus_if.pc !== 4'hF) begin
        $display("FAIL pc_15 got %h want F", bus_if.pc); miscompares++;
      end
      if (i == 15 && bus_if.pc !== 4'h0) begin
        $display("FAIL pc_wrap got %h want 0", bus_if.pc); miscompares++;
      end
      if (i >= 14) vectors++;
    end
  endtask

  task automatic test_li_external;
    bus_if.w_bus_in = 8'hA5;
    bus_if.cntrl_bus = W_LI;
    #1;
    if (bus_if.w_bus_oe !== 1'b0 || bus_if.w_bus_out !== 8'h00) begin
      $display("FAIL li_oe got oe=%b out=%h want 0/00",
               bus_if.w_bus_oe, bus_if.w_bus_out);
      miscompares++;
    end
    vectors++;
    @(posedge clk); #1;
    if (bus_if.opcode !== 4'hA) begin
      $display("FAIL li_opcode got %h want A", bus_if.opcode); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_cp_ep;
    step(W_CP);
    step(W_CP);
    bus_if.cntrl_bus = W_CPEPLM;
    #1;
    if (bus_if.w_bus_out !== 8'h02) begin
      $display("FAIL cpep_drive got %h want 02", bus_if.w_bus_out); miscompares++;
    end
    vectors++;
    @(posedge clk); #1;
    if (bus_if.mar !== 4'h2 || bus_if.pc !== 4'h3) begin
      $display("FAIL cpep_state got mar=%h pc=%h want 2/3", bus_if.mar, bus_if.pc);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_conflict;
    bus_if.cntrl_bus = W_EP_CE;
    #1;
    if (bus_if.w_bus_out !== 8'h03 || bus_if.bus_err !== 1'b0) begin
      $display("FAIL conflict_drive got out=%h err=%b want 03/0",
               bus_if.w_bus_out, bus_if.bus_err);
      miscompares++;
    end
    vectors++;
    @(posedge clk); #1;
    if (bus_if.bus_err !== EXP_ERR) begin
      $display("FAIL conflict_err got %b want %b", bus_if.bus_err, EXP_ERR);
      miscompares++;
    end
    vectors++;
    step(W_IDLE);
    if (bus_if.bus_err !== EXP_ERR) begin
      $display("FAIL conflict_sticky got %b want %b", bus_if.bus_err, EXP_ERR);
      miscompares++;
    end
    vectors++;
    #2 clr = 1'b0;
    #1;
    if (bus_if.bus_err !== 1'b0) begin
      $display("FAIL conflict_clr got %b want 0", bus_if.bus_err); miscompares++;
    end
    vectors++;
    clr = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_drive();
    test_pc_wrap();
    test_li_external();
    test_cp_ep();
    test_conflict();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
